opti_biquad_seq: RTL and testbench
==================================

Name: opti_biquad_seq

Overview:
- Sequencer for the time-multiplexed 4-section Chebyshev II IIR datapath. One shared multiply-accumulate unit evaluates all sections.
- Per accepted sample, it steps the Q2.22 coefficient ROM address through addr 0..19 in [b0 b1 b2 a1 a2] order. It also drives the datapath's operand select, MAC clear/enable and per-section state write-back.
- Sample input and result output use valid/ready handshakes.
- It generates control only. The datapath holds x/y history and the accumulator.

Parameters:
- NSEC, 4: biquad sections per sample. Range 1..6; NSEC*5 must be ≤ 32.
- MAC_LAT, 2: MAC pipeline depth in cycles between last tap issue and result valid. Range 0..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- en  in  1  run enable; 0 aborts and holds in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- out_valid  out  1  filtered result valid at datapath output.
- out_ready  in  1  downstream accepts result.
- coeff_addr  out  5  coefficient ROM address = sec*5 + tap.
- op_sel  out  3  operand: 0=x, 1=x1, 2=x2, 3=y1, 4=y2 of current section.
- sec_idx  out  3  current section 0..NSEC-1.
- mac_clr  out  1  load product instead of accumulating (first tap).
- mac_en  out  1  MAC issues a product this cycle.
- st_we  out  1  datapath shifts section history: x2<=x1, x1<=x, y2<=y1, y1<=acc. acc becomes next section's x.
- acc_ovf  in  1  datapath accumulator overflow/saturation indication.
- clr_stat  in  1  clears ovf_flag.
- ovf_flag  out  1  sticky overflow status.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: wait for a sample.
  - MAC: tap counter t=0..4.
  - DRAIN: MAC_LAT cycles; skipped if MAC_LAT=0.
  - WB: 1 cycle.
  - OUT: hold result until accepted.
- Reset: state=IDLE, sec=0, t=0, all outputs 0.
- in_ready = (state==IDLE) & en. Combinational; the only output that depends on an input.
- All other outputs are decoded from registered state.
- IDLE: handshake (in_valid & in_ready) at cycle 0 → MAC, sec=0, t=0 at cycle 1.
- MAC cycle:
  - mac_en=1, coeff_addr=sec*5+t, op_sel=t, sec_idx=sec.
  - mac_clr=1 only at t=0.
  - t=4 → DRAIN, or WB if MAC_LAT=0.
- Outside MAC: coeff_addr=0, op_sel=0, mac_en=0, mac_clr=0.
- DRAIN: counts MAC_LAT cycles, then → WB.
- WB:
  - st_we=1, sec_idx=sec.
  - acc_ovf sampled here; if 1, ovf_flag set.
  - If sec<NSEC-1: sec+1, t=0 → MAC. Otherwise → OUT.
- OUT: out_valid=1 held until out_ready. On out_valid & out_ready → IDLE, sec=0.
- Latency: out_valid first high at cycle 1 + NSEC*(5+MAC_LAT+1), which is 33 with defaults.
- Throughput: min sample period 2 + NSEC*(5+MAC_LAT+1) cycles (34 with defaults, out_ready=1).
- out_valid never drops without acceptance while en=1.
- en=0 in any non-IDLE state:
  - Next cycle state=IDLE, sec=0, t=0.
  - No st_we or out_valid is issued after the abort edge; a partial sample is discarded.
  - ovf_flag is unaffected.
- ovf_flag: a set (WB & acc_ovf) and clr_stat in the same cycle → set wins. Otherwise clr_stat clears it next cycle.
- in_valid while busy is ignored (in_ready=0). Upstream must hold the sample.
- Async reset mid-sample returns immediately to the reset values.

Test Plan:
- Reset, en=1, single in_valid pulse at cycle 0, out_ready=1 → coeff_addr seq:
  - 0,1,2,3,4 at cycles 1-5; mac_clr only at cycle 1.
  - st_we at 8, 16, 24, 32; addr 5..9 at 9-13; addr 15..19 at 25-29.
  - out_valid at 33 only; next in_ready at 34.
- out_ready held 0 for 10 cycles after out_valid → out_valid stays 1, busy=1, in_ready=0, no new mac_en. Release → IDLE next cycle.
- MAC_LAT=0 build → st_we at cycles 6, 12, 18, 24; out_valid at 25.
- en deasserted at cycle 12 (section 1 MAC) → IDLE at 13. No further st_we/out_valid. New sample after en=1 restarts at addr 0.
- acc_ovf=1 only on the 2nd WB (cycle 16) → ovf_flag=1 from cycle 17, sticky across samples. clr_stat at a non-WB cycle → 0 next cycle. clr_stat coincident with a WB having acc_ovf=1 → stays 1.
- Back-to-back in_valid=1 continuously, out_ready=1 → samples accepted every 34 cycles; op_sel per MAC run = 0,1,2,3,4.

Source files
------------

// File: rtl/opti_biquad_seq_if.sv
// Handshake and datapath-control bundle between the biquad sequencer (master)
// and the shared-MAC datapath plus sample source/sink (slave).
interface opti_biquad_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] coeff_addr;
  logic [2:0] op_sel;
  logic [2:0] sec_idx;
  logic       mac_clr;
  logic       mac_en;
  logic       st_we;
  logic       acc_ovf;

  modport master (
    input  in_valid, out_ready, acc_ovf,
    output in_ready, out_valid, coeff_addr, op_sel, sec_idx,
           mac_clr, mac_en, st_we
  );

  modport slave (
    output in_valid, out_ready, acc_ovf,
    input  in_ready, out_valid, coeff_addr, op_sel, sec_idx,
           mac_clr, mac_en, st_we
  );
endinterface

// File: rtl/opti_biquad_seq.sv
// Control sequencer for a time-multiplexed NSEC-section biquad cascade sharing
// one MAC: steps taps, drains the MAC pipeline, writes back section history.
module opti_biquad_seq #(
  parameter int NSEC    = 4,
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr_stat,
  output logic               ovf_flag,
  output logic               busy,
  opti_biquad_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_WB    = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [2:0] SEC_LAST = 3'(NSEC - 1);
  localparam logic [2:0] LAT_LAST = 3'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam logic [2:0] TAP_LAST = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] sec_q, sec_d;
  // Shared counter: tap index in MAC, drain cycle index in DRAIN.
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sec_q    <= '0;
      cnt_q    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cnt_q   <= cnt_d;
      // A new overflow outranks a simultaneous clear so no event is lost.
      if (state_q == S_WB && bus.acc_ovf)
        ovf_flag <= 1'b1;
      else if (clr_stat)
        ovf_flag <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_IDLE;
      sec_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_d = S_MAC;
            sec_d   = '0;
            cnt_d   = '0;
          end
        end
        S_MAC: begin
          if (cnt_q == TAP_LAST) begin
            cnt_d   = '0;
            state_d = (MAC_LAT == 0) ? S_WB : S_DRAIN;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == LAT_LAST) begin
            cnt_d   = '0;
            state_d = S_WB;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_WB: begin
          cnt_d = '0;
          if (sec_q == SEC_LAST) begin
            state_d = S_OUT;
          end else begin
            sec_d   = sec_q + 3'd1;
            state_d = S_MAC;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
            sec_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          sec_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Everything except in_ready is a pure decode of registered state.
  always_comb begin
    bus.in_ready   = (state_q == S_IDLE) && en;
    bus.out_valid  = (state_q == S_OUT);
    bus.mac_en     = (state_q == S_MAC);
    bus.mac_clr    = (state_q == S_MAC) && (cnt_q == 3'd0);
    bus.st_we      = (state_q == S_WB);
    bus.sec_idx    = sec_q;
    bus.coeff_addr = '0;
    bus.op_sel     = '0;
    if (state_q == S_MAC) begin
      bus.coeff_addr = 5'(sec_q) * 5'd5 + 5'(cnt_q);
      bus.op_sel     = cnt_q;
    end
    busy = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_opti_biquad_seq.sv
// Bench for opti_biquad_seq: default (MAC_LAT=2) and MAC_LAT=0 builds run side
// by side against a cycle-offset schedule model of one sample.
module tb_opti_biquad_seq;
  localparam int NSEC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr_stat = 1'b0;
  logic ovf0, ovf1, busy0, busy1;

  opti_biquad_seq_if if0 ();
  opti_biquad_seq_if if1 ();

  opti_biquad_seq #(.NSEC(NSEC), .MAC_LAT(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat),
    .ovf_flag(ovf0), .busy(busy0), .bus(if0)
  );
  opti_biquad_seq #(.NSEC(NSEC), .MAC_LAT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_stat(clr_stat),
    .ovf_flag(ovf1), .busy(busy1), .bus(if1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat[2] = '{2, 0};
  int exp_lat[2] = '{33, 25};
  int exp_per[2] = '{34, 26};

  // Model: active flag plus cycles elapsed since acceptance.
  bit act[2];
  int k[2];
  bit movf[2];
  bit prev_ov[2];
  int acc_cyc[2];
  int last_acc[2];
  bit chk_tp = 1'b0;

  logic cur_iv, cur_or, cur_ao, cur_cs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; k[d] = 0; movf[d] = 1'b0; prev_ov[d] = 1'b0;
    end
  endtask

  task automatic eval(input int d, input logic ir, input logic ov,
                      input logic [4:0] addr, input logic [2:0] op, input logic [2:0] si,
                      input logic clr, input logic me, input logic we,
                      input logic of, input logic by);
    int p, tot, s, r;
    logic x_me, x_clr, x_we, x_ov;
    logic [4:0] x_addr;
    logic [2:0] x_op;
    string pf;
    pf = $sformatf("d%0d_", d);
    p = 5 + lat[d] + 1;
    tot = NSEC * p;
    s = 0; r = 0;
    x_me = 1'b0; x_clr = 1'b0; x_we = 1'b0; x_addr = '0; x_op = '0;
    if (act[d] && k[d] <= tot) begin
      s = (k[d] - 1) / p;
      r = (k[d] - 1) % p;
      if (r < 5) begin
        x_me = 1'b1; x_clr = (r == 0); x_addr = 5'(s * 5 + r); x_op = 3'(r);
      end
      x_we = (r == p - 1);
    end
    x_ov = act[d] && (k[d] > tot);
    check({pf, "in_ready"}, ir, !act[d] && en);
    check({pf, "out_valid"}, ov, x_ov);
    check({pf, "mac_en"}, me, x_me);
    check({pf, "mac_clr"}, clr, x_clr);
    check({pf, "coeff_addr"}, addr, x_addr);
    check({pf, "op_sel"}, op, x_op);
    check({pf, "st_we"}, we, x_we);
    check({pf, "ovf_flag"}, of, movf[d]);
    check({pf, "busy"}, by, act[d]);
    if (x_me || x_we) check({pf, "sec_idx"}, si, 3'(s));
    if (ov && !prev_ov[d]) check({pf, "latency"}, cyc - acc_cyc[d], exp_lat[d]);
    prev_ov[d] = ov;
    if (x_we && cur_ao) movf[d] = 1'b1;
    else if (cur_cs) movf[d] = 1'b0;
    if (!en) begin
      act[d] = 1'b0; k[d] = 0;
    end else if (!act[d]) begin
      if (cur_iv) begin
        if (chk_tp && last_acc[d] >= 0) check({pf, "period"}, cyc - last_acc[d], exp_per[d]);
        last_acc[d] = cyc; acc_cyc[d] = cyc;
        act[d] = 1'b1; k[d] = 1;
      end
    end else if (k[d] <= tot) begin
      k[d]++;
    end else if (cur_or) begin
      act[d] = 1'b0; k[d] = 0;
    end
  endtask

  task automatic step(input logic e, input logic iv, input logic ordy,
                      input logic ao, input logic cs);
    @(posedge clk);
    #1;
    en = e; clr_stat = cs;
    cur_iv = iv; cur_or = ordy; cur_ao = ao; cur_cs = cs;
    if0.in_valid = iv; if1.in_valid = iv;
    if0.out_ready = ordy; if1.out_ready = ordy;
    if0.acc_ovf = ao; if1.acc_ovf = ao;
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      eval(0, if0.in_ready, if0.out_valid, if0.coeff_addr, if0.op_sel, if0.sec_idx,
           if0.mac_clr, if0.mac_en, if0.st_we, ovf0, busy0);
      eval(1, if1.in_ready, if1.out_valid, if1.coeff_addr, if1.op_sel, if1.sec_idx,
           if1.mac_clr, if1.mac_en, if1.st_we, ovf1, busy1);
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy0"}, busy0, 1'b0);
    check({tag, "_busy1"}, busy1, 1'b0);
    check({tag, "_ovf0"}, ovf0, 1'b0);
    check({tag, "_macen0"}, if0.mac_en, 1'b0);
    check({tag, "_stwe0"}, if0.st_we, 1'b0);
    check({tag, "_outv0"}, if0.out_valid, 1'b0);
    check({tag, "_addr0"}, if0.coeff_addr, 5'd0);
    check({tag, "_macen1"}, if1.mac_en, 1'b0);
    check({tag, "_outv1"}, if1.out_valid, 1'b0);
    check({tag, "_inrdy0"}, if0.in_ready, 1'b0);
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.acc_ovf = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.acc_ovf = 1'b0;
    cur_iv = 1'b0; cur_or = 1'b0; cur_ao = 1'b0; cur_cs = 1'b0;
    last_acc = '{-1, -1};
    acc_cyc = '{0, 0};
    model_reset();

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Single sample, immediate acceptance of the result.
    step(1, 1, 1, 0, 0);
    repeat (40) step(1, 0, 1, 0, 0);

    // Result held back for a while by the sink.
    step(1, 1, 0, 0, 0);
    repeat (45) step(1, 0, 0, 0, 0);
    repeat (5) step(1, 0, 1, 0, 0);

    // Abort during section 1, then a fresh sample.
    step(1, 1, 1, 0, 0);
    repeat (11) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (40) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    repeat (40) step(1, 0, 1, 0, 0);

    // Overflow on the second write-back only, then clear paths.
    step(1, 1, 1, 0, 0);
    for (int c = 1; c <= 40; c++) step(1, 0, 1, (c == 16), 0);
    step(1, 0, 1, 0, 1);
    step(1, 1, 1, 0, 0);
    for (int c = 1; c <= 40; c++) step(1, 0, 1, (c == 8), (c == 8));
    step(1, 0, 1, 0, 1);

    // Continuous input, continuous output acceptance.
    last_acc = '{-1, -1};
    chk_tp = 1'b1;
    repeat (150) step(1, 1, 1, 0, 0);
    chk_tp = 1'b0;

    // Randomized traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(9) < 7),
           ($urandom_range(9) == 0), ($urandom_range(19) == 0));
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
